instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Encodes instruction requests (kind + register/immediate fields) into 32-bit words and
//  writes them sequentially into instruction memory. It is the encode-side counterpart of
//  the opcode decoder and is used by the boot/test loader to fill imem before the core runs.
//  Upstream side: valid/ready handshake. Downstream side: imem write port with an
//  internal address counter.
// PARAMETERS
//  ADDR_W     12  imem address width; last address = 2**ADDR_W-1
//  BASE_ADDR  0   address of the first write after reset/clear (ADDR_W bits)
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  clear      in   1       sync pulse: abort current op, address <= BASE_ADDR, leave FULL
//  in_valid   in   1       request valid
//  in_ready   out  1       block can accept a request
//  in_kind    in   3       000 ALU, 001 ADDI, 010 SW, 011 LW, 1xx illegal
//  in_rd      in   5       rd (data register for SW)
//  in_rs      in   5       rs
//  in_rt      in   5       rt (ALU only)
//  in_shamt   in   5       shamt (ALU only)
//  in_aluop   in   5       ALU op (ALU only)
//  in_imm     in   17      immediate (ADDI/SW/LW)
//  imem_we    out  1       one-cycle write strobe
//  imem_addr  out  ADDR_W  write address
//  imem_data  out  32      encoded word
//  full       out  1       last address written; no further requests accepted
//  err        out  1       one-cycle pulse: illegal kind dropped (only with the macro)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE, addr=BASE_ADDR, imem_we=0, imem_data=0,
//    imem_addr=BASE_ADDR, full=0, err=0.
//  - Opcodes [31:27]: ALU 00000, ADDI 00101, SW 00111, LW 01000.
//  - R word (ALU): op|rd[26:22]|rs[21:17]|rt[16:12]|shamt[11:7]|aluop[6:2]|2'b00.
//  - I word (ADDI/SW/LW): op|rd[26:22]|rs[21:17]|imm[16:0]. Unused fields ignored.
//  - FSM IDLE -> ENC -> WR -> (IDLE | FULL):
//      IDLE: in_ready=1; on in_valid capture all fields, go to ENC.
//      ENC:  in_ready=0; register the encoded word in imem_data; go to WR.
//      WR:   imem_we=1 for exactly one cycle at imem_addr.
//            If addr==2**ADDR_W-1: go to FULL, addr holds. Otherwise addr+1, go to IDLE.
//      FULL: in_ready=0, full=1; leave only on clear.
//  - Latency: accept at cycle N, imem_we at N+2. Throughput: 1 request per 3 cycles.
//  - imem_data/imem_addr remain stable while imem_we=1. imem_data holds its last value
//    otherwise.
//  - clear beats every other event in the same cycle:
//      in ENC/WR it aborts (no imem_we that cycle or later) and goes to IDLE;
//      a request offered in the same cycle as clear is not accepted.
//  - No wrap-around: the address never passes 2**ADDR_W-1. BASE_ADDR > 0 shrinks capacity.
//  - reset_n asserted mid-operation: the pending write is lost and all outputs go to
//    reset values immediately.
// CONFIGURATION
//  INSTR_ENC_ILLEGAL_TRAP_EN
//   defined:     a request with in_kind=1xx is accepted (handshake completes) but dropped;
//                err pulses 1 cycle in the ENC slot; no write, address unchanged; back to
//                IDLE.
//   not defined: 1xx is encoded as an all-zero word (NOP = ALU with zero fields) and
//                written normally; err is tied to 0.
// TESTING
//  1 ALU rd=1 rs=2 rt=3 shamt=0 aluop=0 after reset
//    -> imem_we at N+2, addr=0, data=0x00443000.
//  2 ADDI rd=4 rs=0 imm=0x1FFFF, then LW rd=5 rs=6 imm=8 back-to-back
//    -> data 0x2901FFFF @0, then 0x414C0008 @1; in_ready low 2 cycles after each accept.
//  3 ADDR_W=2, five SW requests
//    -> writes at 0..3; full=1 after the 4th write; 5th held (in_ready=0); clear -> accepted at 0.
//  4 clear asserted in the ENC cycle
//    -> no imem_we, addr unchanged, IDLE next cycle; reset_n low in WR -> all outputs at reset values.
//  5 in_kind=3'b110
//    -> macro defined: err pulse, no write, addr unchanged;
//       macro undefined: word 0x00000000 written, addr+1.
//  6 in_valid held high with random fields
//    -> in_ready follows the 1-of-3 pattern; fields sampled only on the accept cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes ALU/ADDI/SW/LW requests into 32-bit words and writes them sequentially to imem.
// Optional macro INSTR_ENC_ILLEGAL_TRAP_EN: drop 1xx kinds with an err pulse instead of writing a NOP.
module instr_encoder_loader #(
    parameter int               ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} state_t;

    localparam logic [4:0]        OP_ALU    = 5'b00000;
    localparam logic [4:0]        OP_ADDI   = 5'b00101;
    localparam logic [4:0]        OP_SW     = 5'b00111;
    localparam logic [4:0]        OP_LW     = 5'b01000;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t      state;
    logic [2:0]  kind_q;
    logic [4:0]  rd_q, rs_q, rt_q, shamt_q, aluop_q;
    logic [16:0] imm_q;
    logic        we_q;
    logic [31:0] word;

    always_comb begin
        word = 32'h0;
        case (kind_q)
            3'b000:  word = {OP_ALU, rd_q, rs_q, rt_q, shamt_q, aluop_q, 2'b00};
            3'b001:  word = {OP_ADDI, rd_q, rs_q, imm_q};
            3'b010:  word = {OP_SW, rd_q, rs_q, imm_q};
            3'b011:  word = {OP_LW, rd_q, rs_q, imm_q};
            default: word = 32'h0;
        endcase
    end

    // clear wins over a same-cycle request and over a write already in flight
    assign in_ready = (state == S_IDLE) && !clear;
    assign imem_we  = we_q && !clear;

`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            kind_q    <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            shamt_q   <= '0;
            aluop_q   <= '0;
            imm_q     <= '0;
            we_q      <= 1'b0;
            imem_addr <= BASE_ADDR;
            imem_data <= '0;
            full      <= 1'b0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else if (clear) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            imem_addr <= BASE_ADDR;
            full      <= 1'b0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
            err_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        kind_q  <= in_kind;
                        rd_q    <= in_rd;
                        rs_q    <= in_rs;
                        rt_q    <= in_rt;
                        shamt_q <= in_shamt;
                        aluop_q <= in_aluop;
                        imm_q   <= in_imm;
                        state   <= S_ENC;
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
                        err_q   <= in_kind[2];
`endif
                    end
                end
                S_ENC: begin
`ifdef INSTR_ENC_ILLEGAL_TRAP_EN
                    if (kind_q[2]) begin
                        state <= S_IDLE;
                    end else begin
                        imem_data <= word;
                        we_q      <= 1'b1;
                        state     <= S_WR;
                    end
`else
                    imem_data <= word;
                    we_q      <= 1'b1;
                    state     <= S_WR;
`endif
                end
                S_WR: begin
                    // the last address is written once and then the block parks in FULL
                    if (imem_addr == LAST_ADDR) begin
                        full  <= 1'b1;
                        state <= S_FULL;
                    end else begin
                        imem_addr <= imem_addr + ADDR_W'(1);
                        state     <= S_IDLE;
                    end
                end
                S_FULL:  full <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
